// File: rtl/adder_fault_campaign_ctrl.sv
// Fault-injection campaign sequencer for the gate-level 32-bit ADDER.
// It accepts operand vectors, steps each one through the enabled fault
// modes ({f1,f0}), waits for the adder to settle, captures its output and
// reports it next to the golden sum. It also keeps the vector and
// mismatch counters for the campaign.
// Optional build macro: ADDER_FAULT_STOP_ON_FIRST_EN ends the campaign
// right after the first reported mismatch has been handshaken.
module adder_fault_campaign_ctrl #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       mode_mask,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [WIDTH-1:0] vec_a,
    input  logic [WIDTH-1:0] vec_b,
    input  logic             vec_last,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_f0,
    output logic             add_f1,
    input  logic [WIDTH-1:0] add_sum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic [WIDTH-1:0] res_expected,
    output logic [1:0]       res_mode,
    output logic             res_mismatch,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_REPORT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       mask_q, mask_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [1:0]       mode_q, mode_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic [1:0]       first_mode;
    logic [3:0]       higher_mask;
    logic [1:0]       next_mode;
    logic             has_higher;
    logic             mismatch;

    assign mismatch = (sum_q != exp_q);

    // Mode selection: lowest enabled mode, and the next enabled mode above the current one
    always_comb begin
        first_mode  = 2'd0;
        next_mode   = 2'd0;
        higher_mask = 4'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_mode = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            higher_mask[i] = mask_q[i] && (2'(i) > mode_q);
        end
        for (int i = 3; i >= 0; i--) begin
            if (higher_mask[i]) begin
                next_mode = 2'(i);
            end
        end
        has_higher = |higher_mask;
    end

    // State and datapath registers; abort clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            last_q    <= 1'b0;
            exp_q     <= '0;
            sum_q     <= '0;
            mode_q    <= '0;
            settle_q  <= '0;
            vec_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            a_q       <= a_d;
            b_q       <= b_d;
            last_q    <= last_d;
            exp_q     <= exp_d;
            sum_q     <= sum_d;
            mode_q    <= mode_d;
            settle_q  <= settle_d;
            vec_cnt_q <= vec_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // Next-state and datapath update; operands/mode only move on entry to APPLY (or clear on return to IDLE)
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        a_d       = a_q;
        b_d       = b_q;
        last_d    = last_q;
        exp_d     = exp_q;
        sum_d     = sum_q;
        mode_d    = mode_q;
        settle_d  = settle_q;
        vec_cnt_d = vec_cnt_q;
        mis_cnt_d = mis_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d    = mode_mask;
                    vec_cnt_d = '0;
                    mis_cnt_d = '0;
                    state_d   = (mode_mask == 4'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (vec_valid) begin
                    a_d      = vec_a;
                    b_d      = vec_b;
                    last_d   = vec_last;
                    exp_d    = vec_a + vec_b;
                    mode_d   = first_mode;
                    settle_d = '0;
                    if (vec_cnt_q != '1) begin
                        vec_cnt_d = vec_cnt_q + CNT_W'(1);
                    end
                    state_d  = S_APPLY;
                end
            end
            S_APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    sum_d   = add_sum;
                    state_d = S_REPORT;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    if (mismatch && (mis_cnt_q != '1)) begin
                        mis_cnt_d = mis_cnt_q + CNT_W'(1);
                    end
                    if (has_higher) begin
                        mode_d   = next_mode;
                        settle_d = '0;
                        state_d  = S_APPLY;
                    end else if (last_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
`ifdef ADDER_FAULT_STOP_ON_FIRST_EN
                    if (mismatch) begin
                        mode_d   = mode_q;
                        settle_d = settle_q;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_DONE: begin
                a_d     = '0;
                b_d     = '0;
                mode_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state and the held datapath registers
    always_comb begin
        vec_ready    = (state_q == S_LOAD);
        res_valid    = (state_q == S_REPORT);
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        add_a        = a_q;
        add_b        = b_q;
        add_f0       = mode_q[0];
        add_f1       = mode_q[1];
        res_sum      = sum_q;
        res_expected = exp_q;
        res_mode     = mode_q;
        res_mismatch = mismatch;
        vec_cnt      = vec_cnt_q;
        mismatch_cnt = mis_cnt_q;
    end

endmodule

// File: tb/tb_adder_fault_campaign_ctrl.sv
// Self-checking bench for adder_fault_campaign_ctrl. A behavioural adder
// with selectable bit-0 corruption drives add_sum; expected results come
// from a per-vector list of enabled modes built from plain arithmetic.
// Honours ADDER_FAULT_STOP_ON_FIRST_EN when the design is built with it.
module tb_adder_fault_campaign_ctrl;

    localparam int WIDTH  = 32;
    localparam int SETTLE = 2;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       mode_mask;
    logic             vec_valid;
    logic             vec_ready;
    logic [WIDTH-1:0] vec_a;
    logic [WIDTH-1:0] vec_b;
    logic             vec_last;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_f0;
    logic             add_f1;
    logic [WIDTH-1:0] add_sum;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic [WIDTH-1:0] res_expected;
    logic [1:0]       res_mode;
    logic             res_mismatch;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] mismatch_cnt;

    // Adder fault model: flips bit 0 in the selected modes, optionally only for one operand A
    logic [3:0]       badModes;
    logic             matchEn;
    logic [WIDTH-1:0] matchA;
    logic             corruptNow;

    logic [WIDTH-1:0] vecA [8];
    logic [WIDTH-1:0] vecB [8];

    int nAsserts = 0;
    int nFail    = 0;

    adder_fault_campaign_ctrl #(
        .WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode_mask(mode_mask),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_a(vec_a),
        .vec_b(vec_b), .vec_last(vec_last), .add_a(add_a), .add_b(add_b),
        .add_f0(add_f0), .add_f1(add_f1), .add_sum(add_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_expected(res_expected), .res_mode(res_mode),
        .res_mismatch(res_mismatch), .busy(busy), .done(done),
        .vec_cnt(vec_cnt), .mismatch_cnt(mismatch_cnt)
    );

    always #5 clk = ~clk;

    assign corruptNow = badModes[{add_f1, add_f0}] && (!matchEn || (add_a == matchA));
    assign add_sum    = (add_a + add_b) ^ {{(WIDTH-1){1'b0}}, corruptNow};

    // Hard time limit so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic startCampaign(input logic [3:0] mask);
        mode_mask = mask;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        mode_mask = 4'($urandom);
        checkOutput("busy_after_start", busy, 1);
        checkOutput("start_to_vec_ready", vec_ready, (mask != 4'd0));
    endtask

    // Feed nVec vectors and check every result against the mode-list model
    task automatic applyStimulus(input logic [3:0] mask, input int nVec, input bit randReady);
        int               accepted;
        int               expMis;
        int               lat;
        int               stall;
        bit               stop;
        bit               first;
        bit               bad;
        logic [WIDTH-1:0] gold;
        accepted = 0;
        expMis   = 0;
        stop     = 1'b0;
        for (int v = 0; v < nVec; v++) begin
            if (!stop) begin
                checkOutput("vec_ready_in_load", vec_ready, 1);
                vec_a     = vecA[v];
                vec_b     = vecB[v];
                vec_last  = (v == nVec - 1);
                vec_valid = 1'b1;
                cycle();
                vec_valid = 1'b0;
                vec_a     = $urandom;
                vec_b     = $urandom;
                vec_last  = 1'($urandom);
                accepted++;
                checkOutput("vec_cnt_inc", vec_cnt, accepted);
                lat = 1;
                while (!res_valid && lat < 20) begin
                    cycle();
                    lat++;
                end
                checkOutput("accept_to_res_valid", lat, SETTLE + 1);
                first = 1'b1;
                gold  = vecA[v] + vecB[v];
                for (int m = 0; m < 4; m++) begin
                    if (mask[m] && !stop) begin
                        if (!first) begin
                            lat = 0;
                            while (!res_valid && lat < 20) begin
                                cycle();
                                lat++;
                            end
                            checkOutput("next_mode_settle", lat, SETTLE);
                        end
                        first = 1'b0;
                        bad   = badModes[m] && (!matchEn || (vecA[v] == matchA));
                        stall = randReady ? $urandom_range(0, 3) : 0;
                        for (int s = 0; s <= stall; s++) begin
                            res_ready = (s == stall);
                            checkOutput("res_valid", res_valid, 1);
                            checkOutput("res_mode", res_mode, m);
                            checkOutput("res_expected", res_expected, gold);
                            checkOutput("res_sum", res_sum, gold ^ {{(WIDTH-1){1'b0}}, bad});
                            checkOutput("res_mismatch", res_mismatch, bad);
                            checkOutput("add_a_hold", add_a, vecA[v]);
                            checkOutput("add_b_hold", add_b, vecB[v]);
                            checkOutput("add_f_hold", {add_f1, add_f0}, m);
                            cycle();
                        end
                        res_ready = 1'b0;
                        if (bad) begin
                            expMis++;
`ifdef ADDER_FAULT_STOP_ON_FIRST_EN
                            stop = 1'b1;
`endif
                        end
                    end
                end
            end
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("vec_ready_in_done", vec_ready, 0);
        checkOutput("final_vec_cnt", vec_cnt, accepted);
        checkOutput("final_mismatch_cnt", mismatch_cnt, expMis);
        cycle();
        checkOutput("done_one_cycle", done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_add_a", add_a, 0);
        checkOutput("hold_vec_cnt", vec_cnt, accepted);
        checkOutput("hold_mismatch_cnt", mismatch_cnt, expMis);
    endtask

    initial begin
        int doneSeen;
        int doneAt;
        bit readySeen;
        rst       = 1'b1;
        start     = 1'b0;
        mode_mask = 4'd0;
        vec_valid = 1'b0;
        vec_a     = '0;
        vec_b     = '0;
        vec_last  = 1'b0;
        res_ready = 1'b0;
        badModes  = 4'd0;
        matchEn   = 1'b0;
        matchA    = '0;
        cycle();
        cycle();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_vec_ready", vec_ready, 0);
        checkOutput("reset_res_valid", res_valid, 0);
        checkOutput("reset_add_a", add_a, 0);
        checkOutput("reset_res_sum", res_sum, 0);
        rst = 1'b0;
        cycle();

        $display("[TB] test 1: reset mid-APPLY");
        startCampaign(4'b0001);
        vec_a     = $urandom;
        vec_b     = $urandom;
        vec_last  = 1'b1;
        vec_valid = 1'b1;
        cycle();
        vec_valid = 1'b0;
        checkOutput("apply_drives_a", add_a, vec_a);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_add_a", add_a, 0);
        checkOutput("abort_add_b", add_b, 0);
        checkOutput("abort_add_f", {add_f1, add_f0}, 0);
        checkOutput("abort_vec_cnt", vec_cnt, 0);
        checkOutput("abort_res_sum", res_sum, 0);
        checkOutput("abort_res_expected", res_expected, 0);
        doneSeen = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (done) doneSeen++;
        end
        rst = 1'b0;
        cycle();
        if (done) doneSeen++;
        checkOutput("abort_no_done", doneSeen, 0);
        vecA[0] = $urandom;
        vecB[0] = $urandom;
        startCampaign(4'b0001);
        applyStimulus(4'b0001, 1, 1'b0);

        $display("[TB] test 2: single vector, mode 00");
        vecA[0] = 32'h8AB5127F;
        vecB[0] = 32'h82B5127F;
        startCampaign(4'b0001);
        applyStimulus(4'b0001, 1, 1'b0);
        checkOutput("golden_wrap_const", res_expected, 32'h0D6A24FE);

        $display("[TB] test 3: modes 01 and 10, f1 corrupts bit 0");
        badModes = 4'b1100;
        startCampaign(4'b0110);
        applyStimulus(4'b0110, 1, 1'b0);
        checkOutput("t3_mismatch_cnt", mismatch_cnt, 1);

        $display("[TB] test 4: three vectors, all modes, random backpressure");
        badModes = 4'b0000;
        for (int v = 0; v < 3; v++) begin
            vecA[v] = $urandom;
            vecB[v] = $urandom;
        end
        vecA[2] = 32'hFFFFFFFF;
        vecB[2] = 32'h00000001;
        startCampaign(4'b1111);
        applyStimulus(4'b1111, 3, 1'b1);
        checkOutput("t4_vec_cnt", vec_cnt, 3);

        $display("[TB] test 5: zero mask, start while busy");
        mode_mask = 4'd0;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        doneSeen  = 0;
        doneAt    = -1;
        readySeen = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            if (done) begin
                doneSeen++;
                if (doneAt < 0) doneAt = i;
            end
            if (vec_ready) readySeen = 1'b1;
            cycle();
        end
        checkOutput("zero_mask_done_count", doneSeen, 1);
        checkOutput("zero_mask_done_within_2", (doneAt >= 1) && (doneAt <= 2), 1);
        checkOutput("zero_mask_no_vec_ready", readySeen, 0);
        checkOutput("zero_mask_vec_cnt", vec_cnt, 0);
        checkOutput("zero_mask_mismatch_cnt", mismatch_cnt, 0);
        checkOutput("zero_mask_idle", busy, 0);
        vecA[0] = $urandom;
        vecB[0] = $urandom;
        startCampaign(4'b0001);
        mode_mask = 4'b1111;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        applyStimulus(4'b0001, 1, 1'b0);

        $display("[TB] test 6: mismatch on vector 2 mode 01");
        for (int v = 0; v < 3; v++) begin
            vecA[v] = $urandom;
            vecB[v] = $urandom;
        end
        vecA[0]  = vecA[1] ^ 32'h0000_0010;
        vecA[2]  = vecA[1] ^ 32'h0100_0000;
        badModes = 4'b0010;
        matchEn  = 1'b1;
        matchA   = vecA[1];
        startCampaign(4'b0011);
        applyStimulus(4'b0011, 3, 1'b1);
        checkOutput("t6_mismatch_cnt", mismatch_cnt, 1);
`ifdef ADDER_FAULT_STOP_ON_FIRST_EN
        checkOutput("t6_vec_cnt", vec_cnt, 2);
`else
        checkOutput("t6_vec_cnt", vec_cnt, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/adder_fault_campaign_ctrl.md
Name: adder_fault_campaign_ctrl

Overview:
Sequences fault-injection test campaigns on the gate-level 32-bit ADDER datapath.
- Accepts operand vectors over a valid/ready stream.
- Drives the adder's operand inputs and fault-select pins (f0, f1).
- Steps each vector through a programmable set of fault modes and waits a settle time.
- Captures the adder output and compares it against an internally computed golden sum.
- Reports each result on a valid/ready stream and keeps campaign counters.

Parameters:
- WIDTH, 32, operand/result width
- SETTLE_CYCLES, 2, cycles operands are held before the adder output is sampled (legal values >=1)
- CNT_W, 16, width of the vector and mismatch counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin campaign (pulse); ignored while busy
- mode_mask  in  4  enabled fault modes; bit m enables {f1,f0}=m; sampled on start
- vec_valid  in  1  operand vector valid
- vec_ready  out  1  controller accepts vector
- vec_a  in  WIDTH  operand A
- vec_b  in  WIDTH  operand B
- vec_last  in  1  final vector of campaign
- add_a  out  WIDTH  to adder data1_in
- add_b  out  WIDTH  to adder data2_in
- add_f0  out  1  to adder f0
- add_f1  out  1  to adder f1
- add_sum  in  WIDTH  from adder data_o
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_sum  out  WIDTH  captured adder output
- res_expected  out  WIDTH  golden (vec_a+vec_b) mod 2^WIDTH
- res_mode  out  2  {f1,f0} used for this result
- res_mismatch  out  1  res_sum != res_expected
- busy  out  1  campaign in progress
- done  out  1  one-cycle pulse at campaign end
- vec_cnt  out  CNT_W  vectors accepted this campaign
- mismatch_cnt  out  CNT_W  mismatching results this campaign

Behaviour:

Reset values:
- All outputs are 0 and the FSM is in IDLE.
- rst asserted mid-campaign aborts immediately.
- No done pulse is generated on abort.

States:
- IDLE: add_* = 0, vec_ready = 0. On start: latch mode_mask, clear vec_cnt and mismatch_cnt, go to LOAD. If the latched mask is 0, go to DONE instead.
- LOAD: vec_ready = 1. On vec_valid, latch a, b and last; compute expected; vec_cnt++ (saturating); select the lowest enabled mode; go to APPLY.
- APPLY: drive the latched a, b and {f1,f0} = current mode. Hold for exactly SETTLE_CYCLES cycles. On the clock edge ending the last APPLY cycle, register add_sum into res_sum, then go to REPORT.
- REPORT: res_valid = 1, with all res_* outputs stable until the handshake.
  - On res_valid & res_ready: mismatch_cnt++ if res_mismatch (saturating at all-ones).
  - If a higher enabled mode remains: go to APPLY with the next enabled mode (ascending order).
  - Else if last = 1: go to DONE.
  - Else: go to LOAD.
- DONE: done = 1 for one cycle, then IDLE. The counters hold their values until the next start.

Rules and boundary conditions:
- Operands and fault selects hold their values during REPORT.
- Operands and fault selects change only on the APPLY entry edge.
- busy = 1 in every state except IDLE.
- start is ignored while busy.
- Latency, start to vec_ready: 1 cycle.
- Latency, vector acceptance to first res_valid: SETTLE_CYCLES + 1 cycles.
- Golden sum wraps; the carry-out is discarded.
- Consumer backpressure (res_ready low) stalls indefinitely with no loss of data.

Optional Feature:
ADDER_FAULT_STOP_ON_FIRST_EN
- Defined: after the first REPORT handshake with res_mismatch = 1, go straight to DONE. Remaining modes and vectors are not applied; vec_ready stays 0.
- Undefined: the campaign always runs to vec_last.

Test Plan:
1. Reset mid-APPLY (SETTLE_CYCLES = 2):
   - Stimulus: assert rst during APPLY.
   - Required: all outputs 0 immediately, busy = 0, no done pulse.
   - Then: start with mask 4'b0001 runs normally.
2. Single vector, mask 4'b0001:
   - Stimulus: a = 32'h8AB5127F, b = 32'h82B5127F, last = 1; the adder model returns the correct sum.
   - Required: add_f1/add_f0 = 0/0; res_valid 3 cycles after acceptance; res_expected = 32'h0D6A24FE; res_mismatch = 0.
   - Required afterwards: done pulses; vec_cnt = 1, mismatch_cnt = 0.
3. Same vector, mask 4'b0110, adder model corrupts bit 0 when f1 = 1:
   - Required: two results, modes 01 then 10, in that order.
   - Required: the mode-10 result has res_mismatch = 1; final mismatch_cnt = 1.
4. Three vectors, mask 4'b1111, res_ready toggled randomly:
   - Required: 12 results, each with stable payload while stalled.
   - Required: vec_cnt = 3; modes appear in order 0,1,2,3 for each vector.
5. Zero mask and start while busy:
   - Stimulus: start with mask 0.
   - Required: done 2 cycles after start; vec_ready never 1; counters 0.
   - Stimulus: a second start while busy.
   - Required: ignored; the latched mask is unchanged.
6. With ADDER_FAULT_STOP_ON_FIRST_EN, 3 vectors with a mismatch on vector 2 mode 01:
   - Required: done follows that handshake; vec_cnt = 2; mismatch_cnt = 1.
   - Without the macro, the same stimulus gives vec_cnt = 3.
